// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: operation codes, FSM state encoding and default operand width shared by
// seq_alu and its optional divider.
package seq_alu_pkg;

   localparam int unsigned WidthDefault = 32;

   localparam logic [4:0] OpAdd   = 5'd0;
   localparam logic [4:0] OpSub   = 5'd1;
   localparam logic [4:0] OpAnd   = 5'd2;
   localparam logic [4:0] OpOr    = 5'd3;
   localparam logic [4:0] OpXor   = 5'd4;
   localparam logic [4:0] OpSll   = 5'd5;
   localparam logic [4:0] OpSrl   = 5'd6;
   localparam logic [4:0] OpSra   = 5'd7;
   localparam logic [4:0] OpSlt   = 5'd8;
   localparam logic [4:0] OpSltu  = 5'd9;
   localparam logic [4:0] OpPass  = 5'd10;
   localparam logic [4:0] OpMul   = 5'd11;
   localparam logic [4:0] OpMulhu = 5'd12;
   localparam logic [4:0] OpDivu  = 5'd13;
   localparam logic [4:0] OpRemu  = 5'd14;
   localparam logic [4:0] OpDiv   = 5'd15;
   localparam logic [4:0] OpRem   = 5'd16;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   function automatic logic is_div_op(input logic [4:0] op);
      return (op >= OpDivu) && (op <= OpRem);
   endfunction

endpackage

// File: rtl/seq_alu_div.sv
// seq_alu_div: restoring shift-subtract divider, one quotient bit per cycle for WIDTH cycles.
// Only instantiated when SEQ_ALU_DIV_EN is defined; outputs show the current step's result.
module seq_alu_div
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = WidthDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] q_q, r_q, d_q;
   logic [WIDTH:0]   r_sh;
   logic             fits;

   // q_q shifts dividend bits out at the top while quotient bits enter at the bottom
   always_comb begin
      r_sh      = {r_q, q_q[WIDTH-1]};
      fits      = (r_sh >= {1'b0, d_q});
      remainder = WIDTH'(fits ? (r_sh - {1'b0, d_q}) : r_sh);
      quotient  = {q_q[WIDTH-2:0], fits};
   end

   assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         q_q    <= '0;
         r_q    <= '0;
         d_q    <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         q_q    <= dividend;
         r_q    <= '0;
         d_q    <= divisor;
      end else if (busy_q) begin
         q_q   <= quotient;
         r_q   <= remainder;
         cnt_q <= cnt_q + CW'(1);
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes, single-cycle logic ops and a WIDTH-cycle
// shift-add multiplier. Define SEQ_ALU_DIV_EN to add the iterative divider (ops 13-16).
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = WidthDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             s,
   output logic             c,
   output logic             v
);
   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

   state_e           state_q;
   logic [4:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] last_q, hi_q, lo_q, mcand_q;
   logic [WIDTH:0]   sum, dif, msum;
   logic [WIDTH-1:0] alu_res, iter_res, mul_hi_n, mul_lo_n, div_res;
   logic             alu_def, alu_c, alu_v, iter_v, iter_op, div_v, div_done, calc_last;
   logic [SW-1:0]    shamt;

   assign shamt = b[SW-1:0];
   assign sum   = {1'b0, a} + {1'b0, b};
   assign dif   = {1'b0, a} + {1'b0, ~b} + One;

   always_comb begin
      alu_res = '0;
      alu_def = 1'b1;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OpAdd: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            alu_res = dif[WIDTH-1:0];
            alu_c   = dif[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OpAnd:   alu_res = a & b;
         OpOr:    alu_res = a | b;
         OpXor:   alu_res = a ^ b;
         OpSll:   alu_res = a << shamt;
         OpSrl:   alu_res = a >> shamt;
         OpSra:   alu_res = $signed(a) >>> shamt;
         OpSlt:   alu_res = WIDTH'($signed(a) < $signed(b));
         OpSltu:  alu_res = WIDTH'(a < b);
         OpPass:  alu_res = last_q;
         default: alu_def = 1'b0;
      endcase
   end

   // Right-shifting shift-add multiplier: {hi_q, lo_q} holds the full product after WIDTH steps
   assign msum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_hi_n = msum[WIDTH:1];
   assign mul_lo_n = {msum[0], lo_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
   logic             sgn, a_neg, b_neg, dv_start;
   logic             neg_q_q, neg_r_q, dz_q, ovf_q;
   logic [WIDTH-1:0] dv_q, dv_r, q_fix, r_fix;

   assign iter_op  = (op == OpMul) || (op == OpMulhu) || is_div_op(op);
   assign sgn      = (op == OpDiv) || (op == OpRem);
   assign a_neg    = sgn && a[WIDTH-1];
   assign b_neg    = sgn && b[WIDTH-1];
   assign dv_start = (state_q == StIdle) && in_valid && is_div_op(op);

   seq_alu_div #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (dv_start),
      .dividend (a_neg ? -a : a),
      .divisor  (b_neg ? -b : b),
      .done     (div_done),
      .quotient (dv_q),
      .remainder(dv_r)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (dv_start) begin
         neg_q_q <= a_neg ^ b_neg;
         neg_r_q <= a_neg;
         dz_q    <= (b == '0);
         ovf_q   <= sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      end
   end

   // Magnitude division with sign fix-up; a zero divisor leaves |a| as remainder, so -|a| == a
   assign q_fix   = dz_q ? '1 : (neg_q_q ? -dv_q : dv_q);
   assign r_fix   = neg_r_q ? -dv_r : dv_r;
   assign div_res = ((op_q == OpDivu) || (op_q == OpDiv)) ? q_fix : r_fix;
   assign div_v   = ovf_q;
`else
   assign iter_op  = (op == OpMul) || (op == OpMulhu);
   assign div_res  = '0;
   assign div_v    = 1'b0;
   assign div_done = 1'b0;
`endif

   always_comb begin
      iter_res = mul_lo_n;
      iter_v   = 1'b0;
      if (op_q == OpMulhu) begin
         iter_res = mul_hi_n;
      end else if (op_q != OpMul) begin
         iter_res = div_res;
         iter_v   = div_v;
      end
   end

   assign calc_last = is_div_op(op_q) ? div_done : (cnt_q == CW'(WIDTH - 1));
   assign in_ready  = (state_q == StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         mcand_q   <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         z         <= 1'b0;
         s         <= 1'b0;
         c         <= 1'b0;
         v         <= 1'b0;
      end else begin
         case (state_q)
            StIdle: if (in_valid) begin
               op_q <= op;
               if (iter_op) begin
                  state_q <= StCalc;
                  cnt_q   <= '0;
                  hi_q    <= '0;
                  lo_q    <= a;
                  mcand_q <= b;
               end else begin
                  state_q   <= StDone;
                  out_valid <= 1'b1;
                  result    <= alu_res;
                  last_q    <= alu_res;
                  z         <= alu_def && (alu_res == '0);
                  s         <= alu_res[WIDTH-1];
                  c         <= alu_c;
                  v         <= alu_v;
               end
            end
            StCalc: begin
               hi_q  <= mul_hi_n;
               lo_q  <= mul_lo_n;
               cnt_q <= cnt_q + CW'(1);
               if (calc_last) begin
                  state_q   <= StDone;
                  out_valid <= 1'b1;
                  result    <= iter_res;
                  last_q    <= iter_res;
                  z         <= (iter_res == '0);
                  s         <= iter_res[WIDTH-1];
                  c         <= 1'b0;
                  v         <= iter_v;
               end
            end
            StDone: if (out_ready) begin
               state_q   <= StIdle;
               out_valid <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu at WIDTH=32: directed vector table, randomized
// ops against a behavioural model, plus back-pressure and reset-abort sequences.
module tb_seq_alu;
   import seq_alu_pkg::*;

`ifdef SEQ_ALU_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  op;
   logic [31:0] a, b, result;
   logic        in_valid, in_ready, out_valid, out_ready, z, s, c, v;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .a        (a),
      .b        (b),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .z        (z),
      .s        (s),
      .c        (c),
      .v        (v)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_exp = '0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] r, input logic [3:0] f, input int l);
      vec_t t;
      t.op = o; t.a = x; t.b = y; t.res = r; t.flg = f; t.lat = l;
      vecs.push_back(t);
   endfunction

   // Reference model from the operation definitions; flags packed as {z, s, c, v}
   function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] last, output logic [31:0] r,
                                 output logic [3:0] f, output int lat);
      longint      sx, sy, t;
      logic [63:0] p;
      logic        cf, vf, def;
      sx = $signed(x);
      sy = $signed(y);
      p = {32'h0, x} * {32'h0, y};
      cf = 1'b0; vf = 1'b0; def = 1'b1; lat = 1; r = '0;
      case (o)
         5'd0: begin
            t = sx + sy; r = x + y; cf = ({32'h0, x} + {32'h0, y}) > 64'hFFFFFFFF;
            vf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         5'd1: begin
            t = sx - sy; r = x - y; cf = (x >= y);
            vf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         5'd2: r = x & y;
         5'd3: r = x | y;
         5'd4: r = x ^ y;
         5'd5: r = x << y[4:0];
         5'd6: r = x >> y[4:0];
         5'd7: r = 32'(sx >>> y[4:0]);
         5'd8: r = (sx < sy) ? 32'd1 : 32'd0;
         5'd9: r = (x < y) ? 32'd1 : 32'd0;
         5'd10: r = last;
         5'd11: begin r = p[31:0]; lat = 33; end
         5'd12: begin r = p[63:32]; lat = 33; end
         5'd13, 5'd14: begin
            if (DivEn) begin
               lat = 33;
               if (o == 5'd13) r = (y == 0) ? 32'hFFFFFFFF : x / y;
               else r = (y == 0) ? x : x % y;
            end else def = 1'b0;
         end
         5'd15, 5'd16: begin
            if (DivEn) begin
               lat = 33;
               if (y == 0) r = (o == 5'd15) ? 32'hFFFFFFFF : x;
               else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                  r = (o == 5'd15) ? x : 32'h0; vf = 1'b1;
               end else r = (o == 5'd15) ? 32'(sx / sy) : 32'(sx % sy);
            end else def = 1'b0;
         end
         default: def = 1'b0;
      endcase
      if (!def) begin r = '0; f = 4'b0000; end
      else f = {r == 32'h0, r[31], cf, vf};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, scramble inputs after accept, wait (bounded) for out_valid, then handshake
   task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result;
      f = {z, s, c, v};
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r, er;
      logic [3:0]  f, ef;
      int          lat, el;
      logic        saw;

      op = '0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("reset_state", {out_valid, in_ready, z, s, c, v, result}, {2'b01, 4'b0, 32'h0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      add_vec(OpAdd,   32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0101, 1);
      add_vec(OpAdd,   32'hFFFFFFFF, 32'h1,        32'h0,        4'b1010, 1);
      add_vec(OpSub,   32'h5,        32'h5,        32'h0,        4'b1010, 1);
      add_vec(OpSub,   32'h0,        32'h1,        32'hFFFFFFFF, 4'b0100, 1);
      add_vec(OpSub,   32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011, 1);
      add_vec(OpOr,    32'hF0,       32'h0F,       32'hFF,       4'b0000, 1);
      add_vec(OpXor,   32'hF0F0,     32'hFF00,     32'h0FF0,     4'b0000, 1);
      add_vec(OpSll,   32'h1,        32'h1F,       32'h80000000, 4'b0100, 1);
      add_vec(OpSrl,   32'h80000000, 32'h24,       32'h08000000, 4'b0000, 1);
      add_vec(OpSra,   32'h80000000, 32'h21,       32'hC0000000, 4'b0100, 1);
      add_vec(OpSlt,   32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1);
      add_vec(OpSltu,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b1000, 1);
      add_vec(OpMul,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 33);
      add_vec(OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33);
      add_vec(5'd17,   32'h1234,     32'h5678,     32'h0,        4'b0000, 1);
      add_vec(OpDiv,   32'hFFFFFFF9, 32'h2,        DivEn ? 32'hFFFFFFFD : 32'h0,
              DivEn ? 4'b0100 : 4'b0000, DivEn ? 33 : 1);
      add_vec(OpRem,   32'hFFFFFFF9, 32'h2,        DivEn ? 32'hFFFFFFFF : 32'h0,
              DivEn ? 4'b0100 : 4'b0000, DivEn ? 33 : 1);
      add_vec(OpDivu,  32'h5,        32'h0,        DivEn ? 32'hFFFFFFFF : 32'h0,
              DivEn ? 4'b0100 : 4'b0000, DivEn ? 33 : 1);
      add_vec(OpRemu,  32'h5,        32'h0,        DivEn ? 32'h5 : 32'h0, 4'b0000, DivEn ? 33 : 1);
      add_vec(OpDiv,   32'h80000000, 32'hFFFFFFFF, DivEn ? 32'h80000000 : 32'h0,
              DivEn ? 4'b0101 : 4'b0000, DivEn ? 33 : 1);
      add_vec(OpDiv,   32'd10,       32'd2,        DivEn ? 32'd5 : 32'h0, 4'b0000, DivEn ? 33 : 1);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
         check($sformatf("vec%0d_op%0d_result", i, vecs[i].op), r, vecs[i].res);
         check($sformatf("vec%0d_op%0d_flags", i, vecs[i].op), f, vecs[i].flg);
         check($sformatf("vec%0d_op%0d_latency", i, vecs[i].op), lat, vecs[i].lat);
         last_exp = vecs[i].res;
      end

      // Back-pressure: result held for 5 cycles with out_ready low, no new accept
      out_ready = 1'b0;
      op = OpAdd; a = 32'h1234; b = 32'h1111; in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_latency", out_valid, 1'b1);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; op = OpSub; a = $urandom; b = $urandom;
         @(posedge clk); #1;
         check($sformatf("hold_cycle%0d", k), {out_valid, in_ready, result}, {2'b10, 32'h2345});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release", {out_valid, in_ready}, 2'b01);
      last_exp = 32'h2345;
      run_op(OpPass, $urandom, $urandom, r, f, lat);
      check("pass_after_hold", {r, f, 8'(lat)}, {32'h2345, 4'b0000, 8'd1});

      // Reset in the tenth CALC cycle of a multiply aborts it
      op = OpMul; a = 32'd3; b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_outputs", {out_valid, z, s, c, v, result}, 37'h0);
      check("abort_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      check("abort_no_valid", saw, 1'b0);
      last_exp = '0;
      run_op(OpPass, 32'h0, 32'h0, r, f, lat);
      check("pass_after_reset", {r, f, 8'(lat)}, {32'h0, 4'b1000, 8'd1});
      run_op(OpAdd, 32'd2, 32'd3, r, f, lat);
      check("add_after_reset", {r, f, 8'(lat)}, {32'd5, 4'b0000, 8'd1});
      last_exp = 32'd5;

      for (int i = 0; i < 150; i++) begin
         logic [4:0]  o;
         logic [31:0] x, y;
         o = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 16));
         x = pick();
         y = pick();
         model(o, x, y, last_exp, er, ef, el);
         run_op(o, x, y, r, f, lat);
         check($sformatf("rnd%0d_op%0d_a%0h_b%0h_result", i, o, x, y), r, er);
         check($sformatf("rnd%0d_op%0d_flags", i, o), f, ef);
         check($sformatf("rnd%0d_op%0d_latency", i, o), lat, el);
         last_exp = er;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be legal for any even value 8..64.
REQ-002 Port clk  input  1  sole clock; all state on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port op  input  5  operation code (package encoding).
REQ-005 Port a, b  input  WIDTH  operands, sampled on accept.
REQ-006 Port in_valid / in_ready  input / output  1  operation request handshake.
REQ-007 Port out_valid / out_ready  output / input  1  result handshake.
REQ-008 Port result  output  WIDTH  registered result.
REQ-009 Port z, s, c, v  output  1  registered flags: zero, sign, carry, signed overflow.

Function
REQ-010 Ops SHALL be: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASS 10, MUL 11, MULHU 12, DIVU 13, REMU 14, DIV 15, REM 16; other codes give result 0, flags 0, latency 1.
REQ-011 FSM states IDLE, CALC, DONE; accept occurs on an edge with in_valid && in_ready; in_ready SHALL equal (state==IDLE).
REQ-012 Single-cycle ops (0-10, undefined): IDLE->DONE on accept; out_valid high from the next cycle (latency 1).
REQ-013 Iterative ops (11-16): IDLE->CALC on accept; exactly WIDTH CALC cycles, one bit per cycle; CALC->DONE; out_valid high WIDTH+1 cycles after accept.
REQ-014 DONE holds result/flags stable while out_valid && !out_ready; DONE->IDLE on out_valid && out_ready; no new accept in that cycle.
REQ-015 Shifts SHALL use b[log2(WIDTH)-1:0] only; SRA sign-fills.
REQ-016 SLT signed compare, SLTU unsigned compare, result 1 or 0.
REQ-017 PASS SHALL return the previously completed result (internal last-result register, reset 0).
REQ-018 MUL returns low WIDTH bits of a*b; MULHU returns high WIDTH bits of unsigned product.
REQ-019 Divide by zero: DIV/DIVU quotient all ones, REM/REMU remainder = a; still WIDTH+1 latency.
REQ-020 DIV with a = most-negative, b = -1: quotient = a, REM = 0, v = 1.
REQ-021 Signed DIV/REM: quotient truncates toward zero; remainder takes sign of a.
REQ-022 z = (result==0); s = result[WIDTH-1]; c = adder carry-out (SUB: 1 when no borrow); v = signed overflow for ADD/SUB; c, v = 0 for all other ops except REQ-020.
REQ-023 Inputs a, b, op SHALL be ignored except on the accept edge.

Reset
REQ-024 rst SHALL force state IDLE, out_valid 0, result 0, flags 0, last-result 0, iteration counter 0, immediately and independent of clk.
REQ-025 rst asserted during CALC or DONE SHALL abort the operation; no out_valid pulse for it after release.
REQ-026 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SEQ_ALU_DIV_EN: defined -> ops 13-16 per REQ-013/019-021; undefined -> divider absent, ops 13-16 treated as undefined (result 0, latency 1).

Structure
REQ-028 Package seq_alu_pkg SHALL hold op code constants, FSM state encoding and WIDTH default.
REQ-029 Sub-module seq_alu_div (restoring shift-subtract divider, start/done, WIDTH-cycle) SHALL exist only under SEQ_ALU_DIV_EN; multiplier stays inline.

Verification
REQ-030 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, s=1, v=1, c=0, out_valid 1 cycle after accept.
REQ-031 MUL a=0xFFFFFFFF b=0xFFFFFFFF -> MUL 0x00000001, MULHU 0xFFFFFFFE, out_valid exactly 33 cycles after accept.
REQ-032 DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, v=1.
REQ-033 out_ready low 5 cycles in DONE -> result/out_valid stable, in_ready 0; then PASS returns same value.
REQ-034 rst pulse at CALC cycle 10 -> all outputs 0 at once, no out_valid afterwards; next ADD 2+3 -> 5.
REQ-035 Build without SEQ_ALU_DIV_EN, DIV 10/2 -> result 0, latency 1; SRA a=0x80000000 b=0x21 -> 0xC0000000.
